// File: rtl/core_fetch_prefetch.sv
// core_fetch_prefetch: fetch stage with a DEPTH-entry prefetch queue, flushed on EXEC/CSR redirect (rev 1.0)
// Optional macro CORE_FETCH_BYPASS_EN: an empty queue completes a fetch straight from the I-mem response.
`default_nettype none

module core_fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_stage_valid,
  output logic        fetch_stage_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  input  logic        pc_new_valid,
  input  logic [31:0] pc_new,
  input  logic        pc_csr_valid,
  input  logic [31:0] pc_csr,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        m_interrupt_valid,
  input  logic        s_interrupt_valid,
  output logic        ex_instr_access_fault
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        halted_q, halted_d;
  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  logic        err_mem_q   [DEPTH];

  logic        redirect, irq, empty, full, issue, bypass;
  logic        fetch_done, push, pop;
  logic [31:0] target, head_pc, head_instr, done_pc, done_instr;
  logic        head_err, done_err;

  assign redirect   = pc_csr_valid | pc_new_valid;
  assign target     = pc_csr_valid ? pc_csr : pc_new;
  assign irq        = m_interrupt_valid | s_interrupt_valid;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_err   = err_mem_q[rd_ptr_q];

  // full is the registered count, so a pop in the same cycle does not re-open issue until next cycle
  assign imem_valid = ~full & ~halted_q & ~redirect;
  assign imem_addr  = fpc_q;
  assign issue      = imem_valid & imem_ready;

`ifdef CORE_FETCH_BYPASS_EN
  assign bypass = empty & issue;
`else
  assign bypass = 1'b0;
`endif

  assign fetch_stage_ready     = ~empty | bypass;
  assign fetch_done            = fetch_stage_valid & fetch_stage_ready & ~irq & ~redirect;
  assign done_pc               = bypass ? fpc_q : head_pc;
  assign done_instr            = bypass ? imem_rdata : head_instr;
  assign done_err              = bypass ? imem_err : head_err;
  assign ex_instr_access_fault = fetch_done & done_err;

  assign push = issue & ~(bypass & fetch_done);
  assign pop  = fetch_done & ~empty;

  assign instr     = instr_q;
  assign pc        = fetch_stage_valid ? (empty ? fpc_q : head_pc) : last_pc_q;
  assign pc_plus_4 = last_pc_q + 32'd4;

  always_comb begin
    fpc_d     = fpc_q;
    halted_d  = halted_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    instr_d   = instr_q;
    if (redirect) begin
      fpc_d    = target;
      halted_d = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        fpc_d = fpc_q + 32'd4;
        if (imem_err) halted_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (fetch_done) begin
        last_pc_d = done_pc;
        instr_d   = done_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q     <= RESET_VECTOR;
      halted_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= RESET_VECTOR;
      instr_q   <= 32'h0;
    end else begin
      fpc_q     <= fpc_d;
      halted_q  <= halted_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
      instr_q   <= instr_d;
    end
  end

  // Queue payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fpc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      err_mem_q[wr_ptr_q]   <= imem_err;
    end
  end

endmodule

`default_nettype wire

// File: doc/core_fetch_prefetch.md
Name: core_fetch_prefetch

Overview:
Parametrised successor to the single-request FETCH stage. It decouples instruction memory from the controller with a DEPTH-entry prefetch queue, so sequential instructions can be fetched ahead while EXEC/MEM run. Redirects from EXEC (branch/jump) and CSR (trap/xRET) flush the queue. It presents the same controller, EXEC, write-back and trap-handler interface as the existing FETCH stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch queue entries; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_stage_valid  in  1  controller requests one instruction
fetch_stage_ready  out  1  instruction available this cycle
instr  out  32  instruction of last completed fetch (registered)
pc  out  32  head PC while fetch_stage_valid, else PC of last completed fetch
pc_plus_4  out  32  PC of last completed fetch + 4
pc_new_valid, pc_new  in  1, 32  EXEC redirect
pc_csr_valid, pc_csr  in  1, 32  CSR redirect; priority over EXEC
imem_valid, imem_ready, imem_addr, imem_rdata, imem_err  out/in/out/in/in  1,1,32,32,1  I-mem port; rdata/err valid in the cycle imem_valid&imem_ready
m_interrupt_valid, s_interrupt_valid  in  1,1  pending interrupt; blocks fetch completion
ex_instr_access_fault  out  1  completed fetch carried a bus error

Behaviour:
- State: prefetch PC fpc; queue of DEPTH entries {pc, instr, err} with wr/rd pointers and log2(DEPTH)+1 bit count; halted flag; last_pc, instr registers.
- Reset: fpc=RESET_VECTOR, queue empty, halted=0, last_pc=RESET_VECTOR, instr=0. All outputs derive from these: imem_valid=1 (queue not full), fetch_stage_ready=0, ex_instr_access_fault=0.
- redirect = pc_csr_valid|pc_new_valid; target = pc_csr_valid ? pc_csr : pc_new.
- Issue: imem_valid = ~full & ~halted & ~redirect; imem_addr=fpc. On imem_valid&imem_ready: push {fpc, imem_rdata, imem_err}, fpc<=fpc+4 (32-bit wrap, 0xFFFF_FFFC -> 0). If imem_err, halted<=1: no further issue until redirect.
- Completion: irq = m_interrupt_valid|s_interrupt_valid; fetch_stage_ready = ~empty; fetch_done = fetch_stage_valid & fetch_stage_ready & ~irq. On fetch_done: pop head, instr<=head.instr, last_pc<=head.pc.
- ex_instr_access_fault = fetch_done & head.err (same cycle as completion, as before).
- pc = fetch_stage_valid ? (empty ? fpc : head.pc) : last_pc; pc_plus_4 = last_pc+4.
- Push and pop in the same cycle: count unchanged; legal when full (pop frees slot only next cycle: imem_valid uses registered full).
- Redirect cycle: queue flushed (count=0, pointers reset), fpc<=target, halted<=0, no push, no pop (fetch_done forced 0). First redirected instruction completes no earlier than the next cycle.
- Redirect overrides a simultaneous interrupt; interrupt holds the head in queue, prefetch continues until full.
- No alignment check; target used as given.

Optional Feature:
CORE_FETCH_BYPASS_EN: when defined, if the queue is empty and imem_valid&imem_ready, the returned word completes directly: fetch_stage_ready = ~empty | (imem_valid&imem_ready); on fetch_done with empty queue, instr/last_pc take imem_rdata/fpc, fault from imem_err, nothing pushed (fpc still advances). Zero-latency fetch after a redirect-settled cycle. Without it, every instruction passes through the queue (min 1-cycle fetch latency).

Test Plan:
- Reset, imem_ready=1, fetch_stage_valid low 4 cycles -> imem_addr 0x0,0x4,0x8,0xC, then imem_valid=0 (DEPTH=4 full); assert fetch_stage_valid -> instr from 0x0, last_pc=0, pc_plus_4=0x4.
- Full queue, continuous fetch_stage_valid and imem_ready -> one completion and one push per cycle, addresses strictly +4, no bubbles.
- pc_new_valid=1, pc_new=0x100 while queue holds 3 entries -> flush, no fetch_done that cycle, next imem_addr=0x100, next instr from 0x100.
- pc_csr_valid (0x200) and pc_new_valid (0x100) together -> fpc=0x200.
- imem_err on fetch at 0x8 -> prefetch stops; completing 0x8 pulses ex_instr_access_fault for one cycle; issue resumes only after redirect.
- m_interrupt_valid=1 with non-empty queue and fetch_stage_valid -> no fetch_done, instr unchanged; drop irq -> head completes. fpc=0xFFFF_FFFC fetch -> next addr 0x0.
